rs_load_ctrl: RTL and testbench
===============================

RS_LOAD_CTRL -- requirements
Module: rs_load_ctrl

Interface
REQ-001 SHALL have parameter NUM_LINES, default 4, number of load buffer lines; power of two, 2..8.
REQ-002 SHALL have parameter TAG_BASE, default 8'h10, CDB tag of line 0; line i broadcasts tag TAG_BASE+i.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 issue  in  1  request to allocate a line this cycle.
REQ-006 addr_in  in  32  effective load address.
REQ-007 mem_u_b_h_w_in  in  3  load width/sign code, stored unmodified.
REQ-008 issue_ready  out  1  high when the buffer is not full.
REQ-009 issue_tag  out  8  tag the next accepted issue receives (TAG_BASE+tail).
REQ-010 mem_req  out  1  memory read request.
REQ-011 mem_addr  out  32  address of the head line.
REQ-012 mem_u_b_h_w  out  3  width code of the head line.
REQ-013 mem_ack  in  1  memory accepted mem_req this cycle.
REQ-014 mem_done  in  1  load data valid this cycle.
REQ-015 mem_data  in  32  load result.
REQ-016 cdb_req  out  1  request for a CDB broadcast slot.
REQ-017 cdb_out  out  41  {valid, tag[7:0], data[31:0]}; valid equals cdb_req.
REQ-018 cdb_grant  in  1  broadcast taken this cycle (FU result taken).
REQ-019 busy_vec  out  NUM_LINES  per-line busy flags.

Function
REQ-020 Lines SHALL form a circular FIFO: head pointer, tail pointer and count of width log2(NUM_LINES)+1; pointers wrap from NUM_LINES-1 to 0.
REQ-021 issue && issue_ready SHALL write addr_in and mem_u_b_h_w_in into line tail, set its busy bit, and advance tail; the line is visible on the next cycle.
REQ-022 issue while !issue_ready SHALL be ignored with no state change.
REQ-023 issue_ready SHALL equal (count != NUM_LINES) from registered state only; a same-cycle retire does not free a slot for that cycle's issue.
REQ-024 Controller FSM SHALL have states IDLE, MEM_REQ, MEM_WAIT and CDB_REQ.
REQ-025 IDLE -> MEM_REQ on the edge where count != 0 at the start of the cycle.
REQ-026 MEM_REQ: mem_req=1 with head's addr/code; -> MEM_WAIT when mem_ack; if mem_ack && mem_done in the same cycle, capture mem_data and go directly to CDB_REQ.
REQ-027 MEM_WAIT: mem_req=0; on mem_done capture mem_data into a 32-bit result register, -> CDB_REQ.
REQ-028 CDB_REQ: cdb_req=1, cdb_out={1, TAG_BASE+head, result}; hold stable until cdb_grant.
REQ-029 cdb_grant in CDB_REQ SHALL clear head's busy bit, advance head, and decrement count; next state MEM_REQ if count after decrement and concurrent issue is nonzero, else IDLE.
REQ-030 Simultaneous issue and retire SHALL leave count unchanged and update both pointers.
REQ-031 mem_done outside MEM_REQ/MEM_WAIT and cdb_grant outside CDB_REQ SHALL be ignored.
REQ-032 Outside CDB_REQ cdb_out SHALL be all zero; outside MEM_REQ mem_addr/mem_u_b_h_w SHALL still show head contents, mem_req=0.
REQ-033 Minimum issue-to-broadcast latency with ack and done in the same cycle: issue at edge T, mem_req during cycle T+1..T+2 (after IDLE->MEM_REQ edge), cdb_req one cycle after done.
REQ-034 Loads SHALL complete strictly in issue order; at most one load outstanding to memory.

Reset
REQ-035 rst_n low SHALL asynchronously clear all busy bits, head, tail, count, and the result register, and force IDLE; issue_ready=1, issue_tag=TAG_BASE, mem_req=0, cdb_req=0, cdb_out=0.
REQ-036 Reset mid-operation SHALL abandon any outstanding memory load; a mem_done arriving after reset release SHALL be ignored per REQ-031.

Structure
REQ-037 FSM state encoding, CDB field widths/offsets (41-bit layout) and TAG_BASE default SHALL live in the shared define package.
REQ-038 Per-line storage (busy, addr, width code, write-on-allocate, clear-on-retire) SHALL be a sub-module load_buf_line instantiated NUM_LINES times.

Verification
REQ-039 Reset then single issue addr=32'h100, code=3'b010, ack and done same cycle, data=32'hDEADBEEF -> mem_addr=32'h100, then cdb_out={1,8'h10,32'hDEADBEEF}, busy_vec back to 0.
REQ-040 Issue 4 back-to-back with no mem_ack -> issue_ready=0 after the fourth, fifth issue ignored, busy_vec=4'hF, count stays 4.
REQ-041 Fill 4, complete 6 loads with new issues filling freed slots -> tags 10,11,12,13,10,11 in order (tail/head wrap).
REQ-042 Buffer full, issue in the cdb_grant cycle -> issue ignored, count drops to 3, issue_ready=1 next cycle.
REQ-043 cdb_grant held low 5 cycles in CDB_REQ -> cdb_out stable all 5 cycles, no pointer change.
REQ-044 rst_n pulsed low in MEM_WAIT, later mem_done=1 -> no cdb_req, all outputs at reset values.

Source files
------------

// File: rtl/rs_load_ctrl_pkg.sv
// Shared definitions for the reservation-station load controller: FSM encoding,
// CDB packet layout and default tag base.
package rs_load_ctrl_pkg;

  localparam logic [7:0] TAG_BASE_DEFAULT = 8'h10;

  // CDB word: {valid, tag[7:0], data[31:0]}
  localparam int CDB_DATA_LSB  = 0;
  localparam int CDB_DATA_W    = 32;
  localparam int CDB_TAG_LSB   = 32;
  localparam int CDB_TAG_W     = 8;
  localparam int CDB_VALID_BIT = 40;
  localparam int CDB_W         = 41;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    CDB_REQ  = 2'd3
  } ld_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  code;
  } ld_entry_t;

  function automatic logic [CDB_W-1:0] cdb_pack(input logic [CDB_TAG_W-1:0]  tag,
                                                input logic [CDB_DATA_W-1:0] data);
    logic [CDB_W-1:0] p;
    p = '0;
    p[CDB_VALID_BIT]                = 1'b1;
    p[CDB_TAG_LSB +: CDB_TAG_W]     = tag;
    p[CDB_DATA_LSB +: CDB_DATA_W]   = data;
    return p;
  endfunction

endpackage

// File: rtl/rs_load_ctrl_load_buf_line.sv
// One load buffer line: busy flag plus the address/width code captured on allocate.
module load_buf_line
  import rs_load_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      alloc,
  input  logic      retire,
  input  ld_entry_t entry_in,
  output logic      busy,
  output ld_entry_t entry
);

  // Allocate and retire never hit the same line in one cycle (that would need a full
  // buffer accepting an issue), but allocate wins if they ever do.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      entry <= '0;
    end else if (alloc) begin
      busy  <= 1'b1;
      entry <= entry_in;
    end else if (retire) begin
      busy  <= 1'b0;
    end
  end

endmodule

// File: rtl/rs_load_ctrl.sv
// In-order load buffer: circular FIFO of lines, one memory read outstanding at a time,
// results broadcast on the CDB tagged TAG_BASE+line.
module rs_load_ctrl
  import rs_load_ctrl_pkg::*;
#(
  parameter int         NUM_LINES = 4,
  parameter logic [7:0] TAG_BASE  = TAG_BASE_DEFAULT
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue,
  input  logic [31:0]          addr_in,
  input  logic [2:0]           mem_u_b_h_w_in,
  output logic                 issue_ready,
  output logic [7:0]           issue_tag,
  output logic                 mem_req,
  output logic [31:0]          mem_addr,
  output logic [2:0]           mem_u_b_h_w,
  input  logic                 mem_ack,
  input  logic                 mem_done,
  input  logic [31:0]          mem_data,
  output logic                 cdb_req,
  output logic [CDB_W-1:0]     cdb_out,
  input  logic                 cdb_grant,
  output logic [NUM_LINES-1:0] busy_vec
);

  localparam int PW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(NUM_LINES);

  ld_state_e                  state;
  logic [PW-1:0]              head, tail;
  logic [CW-1:0]              count, count_nxt;
  logic [31:0]                result;
  logic                       acc, ret;
  logic [NUM_LINES-1:0]       alloc_vec, retire_vec;
  ld_entry_t                  entry_in;
  ld_entry_t [NUM_LINES-1:0]  line_q;

  // Readiness looks only at registered count; a retire this cycle frees nothing yet.
  assign issue_ready = (count != FULL);
  assign acc         = issue && issue_ready;
  assign ret         = (state == CDB_REQ) && cdb_grant;
  assign count_nxt   = count + CW'(acc) - CW'(ret);
  assign issue_tag   = TAG_BASE + 8'(tail);
  assign entry_in    = '{addr: addr_in, code: mem_u_b_h_w_in};

  generate
    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
      assign alloc_vec[i]  = acc && (tail == PW'(i));
      assign retire_vec[i] = ret && (head == PW'(i));
      load_buf_line u_line (
        .clk      (clk),
        .rst_n    (rst_n),
        .alloc    (alloc_vec[i]),
        .retire   (retire_vec[i]),
        .entry_in (entry_in),
        .busy     (busy_vec[i]),
        .entry    (line_q[i])
      );
    end
  endgenerate

  assign mem_addr    = line_q[head].addr;
  assign mem_u_b_h_w = line_q[head].code;
  assign cdb_out     = cdb_req ? cdb_pack(TAG_BASE + 8'(head), result) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      result  <= '0;
      mem_req <= 1'b0;
      cdb_req <= 1'b0;
    end else begin
      if (acc) tail <= tail + 1'b1;
      count <= count_nxt;
      case (state)
        IDLE: begin
          if (count != '0) begin
            state   <= MEM_REQ;
            mem_req <= 1'b1;
          end
        end
        MEM_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_done) begin
              result  <= mem_data;
              state   <= CDB_REQ;
              cdb_req <= 1'b1;
            end else begin
              state <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (mem_done) begin
            result  <= mem_data;
            state   <= CDB_REQ;
            cdb_req <= 1'b1;
          end
        end
        CDB_REQ: begin
          if (cdb_grant) begin
            head    <= head + 1'b1;
            cdb_req <= 1'b0;
            if (count_nxt != '0) begin
              state   <= MEM_REQ;
              mem_req <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          cdb_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs_load_ctrl.sv
// Scoreboard bench for rs_load_ctrl: queue-of-loads model, random memory/CDB agents.
module tb_rs_load_ctrl;

  localparam int         N  = 4;
  localparam logic [7:0] TB = 8'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue;
  logic [31:0] addr_in;
  logic [2:0]  code_in;
  logic        issue_ready;
  logic [7:0]  issue_tag;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [2:0]  mem_u_b_h_w;
  logic        mem_ack, mem_done;
  logic [31:0] mem_data;
  logic        cdb_req;
  logic [40:0] cdb_out;
  logic        cdb_grant;
  logic [N-1:0] busy_vec;

  rs_load_ctrl #(.NUM_LINES(N), .TAG_BASE(TB)) dut (
    .clk(clk), .rst_n(rst_n), .issue(issue), .addr_in(addr_in), .mem_u_b_h_w_in(code_in),
    .issue_ready(issue_ready), .issue_tag(issue_tag), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_u_b_h_w(mem_u_b_h_w), .mem_ack(mem_ack), .mem_done(mem_done), .mem_data(mem_data),
    .cdb_req(cdb_req), .cdb_out(cdb_out), .cdb_grant(cdb_grant), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  tag;
    logic [31:0] addr;
    logic [2:0]  code;
    logic [31:0] data;
  } ld_t;

  ld_t exp_q[$];
  int  vectors = 0, errors = 0;
  int  n_issued = 0;
  int  ack_pct = 0, done_pct = 0, grant_pct = 0, spur_pct = 0;
  logic pend = 1'b0;

  // Memory contents as seen by the loads; 0x100 reads back 0xDEADBEEF.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'hDEADBFEF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Memory agent: random ack/done latency, occasional stray mem_done while idle.
  initial begin
    logic [31:0] paddr;
    paddr = '0;
    mem_ack = 1'b0; mem_done = 1'b0; mem_data = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_done = 1'b0; mem_data = 32'hBAD00BAD;
      if (pend) begin
        if (int'($urandom_range(99)) < done_pct) begin
          mem_done = 1'b1; mem_data = mem_fn(paddr); pend = 1'b0;
        end
      end else if (mem_req) begin
        if (int'($urandom_range(99)) < ack_pct) begin
          mem_ack = 1'b1; paddr = mem_addr;
          if (int'($urandom_range(99)) < done_pct) begin
            mem_done = 1'b1; mem_data = mem_fn(paddr);
          end else pend = 1'b1;
        end
      end else if (int'($urandom_range(99)) < spur_pct) begin
        mem_done = 1'b1;
      end
    end
  end

  // CDB arbiter agent.
  initial begin
    cdb_grant = 1'b0;
    forever begin
      @(posedge clk); #1;
      cdb_grant = (int'($urandom_range(99)) < grant_pct);
    end
  end

  // Monitor: compare against the queue model, then advance the model.
  initial begin
    logic [N-1:0] bv;
    logic         acc_m, ret_m;
    int           stall;
    ld_t          e;
    stall = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        n_issued = 0;
        stall    = 0;
      end else begin
        chk("issue_ready", issue_ready, exp_q.size() != N);
        chk("issue_tag", issue_tag, TB + 8'(n_issued % N));
        bv = '0;
        foreach (exp_q[k]) bv[exp_q[k].tag - TB] = 1'b1;
        chk("busy_vec", busy_vec, bv);
        chk("cdb_valid_bit", cdb_out[40], cdb_req);
        if (!cdb_req) chk("cdb_out_zero", cdb_out, 41'd0);
        if (exp_q.size() == 0) begin
          chk("mem_req_idle", mem_req, 1'b0);
          chk("cdb_req_idle", cdb_req, 1'b0);
        end else begin
          if (mem_req) begin
            chk("mem_addr", mem_addr, exp_q[0].addr);
            chk("mem_code", mem_u_b_h_w, exp_q[0].code);
          end
          if (cdb_req) chk("cdb_out", cdb_out, {1'b1, exp_q[0].tag, exp_q[0].data});
        end
        acc_m = issue && (exp_q.size() != N);
        ret_m = cdb_req && cdb_grant && (exp_q.size() != 0);
        if (ret_m) begin
          void'(exp_q.pop_front());
          stall = 0;
        end
        if (acc_m) begin
          e.tag = TB + 8'(n_issued % N); e.addr = addr_in; e.code = code_in;
          e.data = mem_fn(addr_in);
          exp_q.push_back(e);
          n_issued++;
        end
        if (exp_q.size() != 0 && !ret_m) stall++;
        if (stall > 300) begin
          chk("watchdog_stall", stall, 0);
          stall = 0;
        end
      end
    end
  end

  initial begin
    int t;
    issue = 1'b0; addr_in = '0; code_in = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", issue_ready, 1'b1);
    chk("rst_tag", issue_tag, 8'h10);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_cdb_req", cdb_req, 1'b0);
    chk("rst_cdb_out", cdb_out, 41'd0);
    chk("rst_busy", busy_vec, 4'h0);

    // Single load, ack+done together: minimum latency.
    rst_n = 1'b1;
    ack_pct = 100; done_pct = 100; grant_pct = 100;
    issue = 1'b1; addr_in = 32'h100; code_in = 3'b010;
    step();
    issue = 1'b0;
    @(negedge clk); chk("lat_mreq_early", mem_req, 1'b0);
    @(negedge clk); chk("lat_mreq", mem_req, 1'b1);
    chk("lat_maddr", mem_addr, 32'h100);
    chk("lat_mcode", mem_u_b_h_w, 3'b010);
    @(negedge clk); chk("lat_cdb", cdb_out, {1'b1, 8'h10, 32'hDEADBEEF});
    @(negedge clk); chk("ret_busy", busy_vec, 4'h0);
    chk("ret_cdb_req", cdb_req, 1'b0);

    // Fill with memory stalled; fifth issue must be dropped.
    ack_pct = 0;
    step();
    issue = 1'b1;
    for (int i = 0; i < 5; i++) begin
      addr_in = $urandom; code_in = 3'($urandom);
      step();
    end
    issue = 1'b0;
    @(negedge clk);
    chk("full_busy", busy_vec, 4'hF);
    chk("full_ready", issue_ready, 1'b0);
    chk("full_tag", issue_tag, 8'h11);

    // Issue during the granting cycle of a full buffer is still refused.
    grant_pct = 0; ack_pct = 100; done_pct = 100;
    t = 0;
    while (!cdb_req && t < 20) begin @(negedge clk); t++; end
    chk("to_cdb_full", cdb_req, 1'b1);
    grant_pct = 100;
    step();
    issue = 1'b1; addr_in = 32'hCAFE0000; code_in = 3'b111;
    @(negedge clk);
    chk("grant_cycle_ready", issue_ready, 1'b0);
    grant_pct = 0;
    step();
    issue = 1'b0;
    @(negedge clk);
    chk("after_grant_busy", busy_vec, 4'hD);
    chk("after_grant_ready", issue_ready, 1'b1);
    chk("after_grant_tag", issue_tag, 8'h11);

    // Broadcast held without grant: everything frozen.
    t = 0;
    while (!cdb_req && t < 20) begin @(negedge clk); t++; end
    chk("to_cdb_hold", cdb_req, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_tag_field", cdb_out[39:32], 8'h12);
      chk("hold_busy", busy_vec, 4'hD);
      chk("hold_issue_tag", issue_tag, 8'h11);
    end

    // Random traffic under a few agent mixes; covers pointer wrap and stray events.
    for (int ph = 0; ph < 3; ph++) begin
      grant_pct = 40 + ph * 25; ack_pct = 90 - ph * 30; done_pct = 30 + ph * 30;
      spur_pct = 15;
      for (int i = 0; i < 400; i++) begin
        issue = (int'($urandom_range(99)) < 30 + ph * 20);
        addr_in = $urandom; code_in = 3'($urandom);
        step();
      end
      issue = 1'b0;
    end

    // Drain.
    ack_pct = 100; done_pct = 100; grant_pct = 100; spur_pct = 0;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("drain_busy", busy_vec, 4'h0);

    // Reset while waiting on memory; the late mem_done must be ignored.
    done_pct = 0;
    step();
    issue = 1'b1; addr_in = 32'h2000; code_in = 3'b101;
    step();
    issue = 1'b0;
    t = 0;
    while (!mem_req && t < 20) begin @(negedge clk); t++; end
    chk("to_mem_req", mem_req, 1'b1);
    @(negedge clk);
    chk("in_wait_mreq", mem_req, 1'b0);
    chk("in_wait_pend", pend, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ready", issue_ready, 1'b1);
    chk("arst_tag", issue_tag, 8'h10);
    chk("arst_mem_req", mem_req, 1'b0);
    chk("arst_cdb_req", cdb_req, 1'b0);
    chk("arst_cdb_out", cdb_out, 41'd0);
    chk("arst_busy", busy_vec, 4'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    done_pct = 100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_cdb_req", cdb_req, 1'b0);
      chk("post_rst_busy", busy_vec, 4'h0);
      chk("post_rst_mem_req", mem_req, 1'b0);
    end
    chk("late_done_delivered", pend, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
